// File: rtl/vga_layer_compositor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_layer_compositor_pkg : shared VGA colours, UI mode codes, fade states  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package vga_layer_compositor_pkg;

  localparam logic [23:0] DEFAULT_KEY_COLOR = 24'hFF00FF;
  localparam logic [23:0] DEFAULT_BG_COLOR  = 24'hFFFFFF;

  localparam logic [7:0] MODE_BOOT     = 8'h00;
  localparam logic [7:0] MODE_MENU     = 8'h01;
  localparam logic [7:0] MODE_GAME     = 8'h02;
  localparam logic [7:0] MODE_SETTINGS = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLANK   = 2'd1,
    ST_FADE_IN = 2'd2
  } fade_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_channel_blend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_channel_blend : 8-bit linear interpolation between p and b by level    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_channel_blend #(
  parameter int FADE_LOG2 = 4
) (
  input  logic [7:0]         p,
  input  logic [7:0]         b,
  input  logic [FADE_LOG2:0] level,
  output logic [7:0]         out
);

  localparam int SUM_W = 8 + FADE_LOG2 + 1;
  localparam logic [FADE_LOG2:0] MAX_LVL = {1'b1, {FADE_LOG2{1'b0}}};

  logic [FADE_LOG2:0] inv_level;
  logic [SUM_W-1:0]   sum;

  // Weights always add to MAX, so the shifted sum stays within 8 bits.
  always_comb begin
    inv_level = MAX_LVL - level;
    sum = SUM_W'(p) * SUM_W'(level) + SUM_W'(b) * SUM_W'(inv_level);
    out = 8'(sum >> FADE_LOG2);
  end

endmodule
`default_nettype wire

// File: rtl/vga_layer_compositor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_layer_compositor : priority layer merge with scene-change fade-in      |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_layer_compositor
  import vga_layer_compositor_pkg::*;
#(
  parameter int               NUM_LAYERS  = 8,
  parameter int               PIX_W       = 24,
  parameter logic [PIX_W-1:0] KEY_COLOR   = PIX_W'(DEFAULT_KEY_COLOR),
  parameter logic [PIX_W-1:0] BG_COLOR    = PIX_W'(DEFAULT_BG_COLOR),
  parameter int               FADE_LOG2   = 4,
  parameter int               HOLD_FRAMES = 2
) (
  input  logic                        vga_clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic                        pix_valid,
  input  logic [7:0]                  scene_id,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS*PIX_W-1:0] layer_data,
  output logic [PIX_W-1:0]            pos_data,
  output logic                        pos_valid,
  output logic                        fade_busy
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [FADE_LOG2:0] MAX_LVL = {1'b1, {FADE_LOG2{1'b0}}};
  localparam logic [FADE_LOG2:0] ONE_LVL = (FADE_LOG2+1)'(1);

  logic [PIX_W-1:0]  sel_comb;
  logic [PIX_W-1:0]  sel_pix;
  logic              sel_valid;
  logic [PIX_W-1:0]  blend_pix;

  fade_state_t        state, state_next;
  logic [FADE_LOG2:0] level, level_next;
  logic [HOLD_W-1:0]  hold, hold_next;
  logic [7:0]         scene_q, scene_next;

  // Walk from lowest priority up so the lowest visible index wins.
  always_comb begin
    sel_comb = BG_COLOR;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_en[k] && (layer_data[k*PIX_W +: PIX_W] != KEY_COLOR))
        sel_comb = layer_data[k*PIX_W +: PIX_W];
    end
    if (!pix_valid)
      sel_comb = BG_COLOR;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_pix   <= BG_COLOR;
      sel_valid <= 1'b0;
      pos_data  <= BG_COLOR;
      pos_valid <= 1'b0;
    end else begin
      sel_pix   <= sel_comb;
      sel_valid <= pix_valid;
      pos_data  <= blend_pix;
      pos_valid <= sel_valid;
    end
  end

  for (genvar c = 0; c < PIX_W / 8; c++) begin : g_chan
    vga_channel_blend #(.FADE_LOG2(FADE_LOG2)) u_blend (
      .p    (sel_pix[c*8 +: 8]),
      .b    (BG_COLOR[c*8 +: 8]),
      .level(level),
      .out  (blend_pix[c*8 +: 8])
    );
  end

  // A scene change outranks a coincident frame_start.
  always_comb begin
    state_next = state;
    level_next = level;
    hold_next  = hold;
    scene_next = scene_q;
    if (scene_id != scene_q) begin
      scene_next = scene_id;
      level_next = '0;
      hold_next  = HOLD_W'(HOLD_FRAMES);
      state_next = ST_BLANK;
    end else if (frame_start) begin
      case (state)
        ST_BLANK: begin
          hold_next = hold - HOLD_W'(1);
          if (hold <= HOLD_W'(1)) begin
            level_next = ONE_LVL;
            state_next = ST_FADE_IN;
          end
        end
        ST_FADE_IN: begin
          level_next = level + ONE_LVL;
          if (level_next == MAX_LVL)
            state_next = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      level     <= MAX_LVL;
      hold      <= '0;
      scene_q   <= 8'h00;
      fade_busy <= 1'b0;
    end else begin
      state     <= state_next;
      level     <= level_next;
      hold      <= hold_next;
      scene_q   <= scene_next;
      fade_busy <= (state_next != ST_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_compositor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_layer_compositor : directed and random checks of the compositor     |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_vga_layer_compositor;

  localparam int NL   = 4;
  localparam int PW   = 24;
  localparam int FL   = 2;
  localparam int HF   = 1;
  localparam int MAXL = 4;
  localparam int SAT  = 1000;
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam logic [23:0] BG  = 24'hFFFFFF;

  logic             vga_clk     = 1'b0;
  logic             rst_n       = 1'b0;
  logic             frame_start = 1'b0;
  logic             pix_valid   = 1'b0;
  logic [7:0]       scene_id    = 8'h00;
  logic [NL-1:0]    layer_en    = '0;
  logic [NL*PW-1:0] layer_data  = '0;
  logic [PW-1:0]    pos_data;
  logic             pos_valid;
  logic             fade_busy;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  vga_layer_compositor #(
    .NUM_LAYERS (NL),
    .PIX_W      (PW),
    .KEY_COLOR  (KEY),
    .BG_COLOR   (BG),
    .FADE_LOG2  (FL),
    .HOLD_FRAMES(HF)
  ) dut (
    .vga_clk    (vga_clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .scene_id   (scene_id),
    .layer_en   (layer_en),
    .layer_data (layer_data),
    .pos_data   (pos_data),
    .pos_valid  (pos_valid),
    .fade_busy  (fade_busy)
  );

  // Reference: level is a function of frame_starts seen since the last scene change.
  function automatic int lvl_of(int fs);
    if (fs < HF) return 0;
    return (fs - HF + 1 > MAXL) ? MAXL : fs - HF + 1;
  endfunction

  function automatic logic [23:0] pick(logic [NL-1:0] en, logic [NL*PW-1:0] d);
    for (int k = 0; k < NL; k++)
      if (en[k] && d[k*PW +: PW] != KEY) return d[k*PW +: PW];
    return BG;
  endfunction

  function automatic logic [23:0] mix(logic [23:0] p, int lvl);
    logic [23:0] r;
    logic [23:0] bg;
    bg = BG;
    for (int c = 0; c < 3; c++)
      r[c*8 +: 8] = 8'((int'(p[c*8 +: 8]) * lvl + int'(bg[c*8 +: 8]) * (MAXL - lvl)) / MAXL);
    return r;
  endfunction

  int          m_fs    = SAT;
  logic [7:0]  m_scene = 8'h00;
  logic [23:0] m_s1    = BG;
  logic        m_s1v   = 1'b0;
  logic [23:0] m_out   = BG;
  logic        m_outv  = 1'b0;
  logic        m_busy  = 1'b0;

  always @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fs = SAT; m_scene = 8'h00; m_s1 = BG; m_s1v = 1'b0;
      m_out = BG; m_outv = 1'b0; m_busy = 1'b0;
    end else begin
      m_out  = mix(m_s1, lvl_of(m_fs));
      m_outv = m_s1v;
      m_s1   = pix_valid ? pick(layer_en, layer_data) : BG;
      m_s1v  = pix_valid;
      if (scene_id != m_scene) begin
        m_scene = scene_id;
        m_fs    = 0;
      end else if (frame_start && m_fs < SAT) begin
        m_fs = m_fs + 1;
      end
      m_busy = (lvl_of(m_fs) < MAXL);
    end
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge vga_clk) begin
    if (rst_n) begin
      chk("model_pos_data", pos_data, m_out);
      chk("model_pos_valid", 24'(pos_valid), 24'(m_outv));
      chk("model_fade_busy", 24'(fade_busy), 24'(m_busy));
    end
  end

  task automatic tick();
    @(posedge vga_clk);
    #2;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic set_layer(input int k, input logic [23:0] v);
    layer_data[k*PW +: PW] = v;
  endtask

  initial begin
    // Reset values while held in reset
    repeat (3) tick();
    chk("reset_pos_data", pos_data, BG);
    chk("reset_pos_valid", 24'(pos_valid), 24'h0);
    chk("reset_fade_busy", 24'(fade_busy), 24'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Priority select and 2-cycle latency
    layer_en = 4'b0110; set_layer(1, 24'h112233); set_layer(2, 24'h445566);
    pix_valid = 1'b1;
    tick();
    chk("lat1_pos_valid", 24'(pos_valid), 24'h0);
    tick();
    chk("prio_pos_data", pos_data, 24'h112233);
    chk("prio_pos_valid", 24'(pos_valid), 24'h1);

    set_layer(1, KEY); repeat (2) tick();
    chk("key_pos_data", pos_data, 24'h445566);
    layer_en = 4'b0000; repeat (2) tick();
    chk("noen_pos_data", pos_data, BG);
    layer_en = 4'b0110; pix_valid = 1'b0; repeat (2) tick();
    chk("inval_pos_data", pos_data, BG);
    chk("inval_pos_valid", 24'(pos_valid), 24'h0);

    // Fade sequence after scene change 3 -> 5 with a black top layer
    pix_valid = 1'b1; layer_en = 4'b0001; set_layer(0, 24'h000000);
    scene_id = 8'd3; tick();
    repeat (6) begin pulse_frame(); tick(); end
    chk("idle_black", pos_data, 24'h000000);
    scene_id = 8'd5; tick();
    chk("fade_busy_rise", 24'(fade_busy), 24'h1);
    repeat (3) tick();
    chk("blank_bg", pos_data, BG);
    pulse_frame(); tick(); chk("fade_l1", pos_data, 24'hBFBFBF);
    pulse_frame(); tick(); chk("fade_l2", pos_data, 24'h7F7F7F);
    pulse_frame(); tick(); chk("fade_l3", pos_data, 24'h3F3F3F);
    pulse_frame();
    chk("busy_fall", 24'(fade_busy), 24'h0);
    tick(); chk("fade_l4", pos_data, 24'h000000);

    // Scene change coincident with frame_start: the frame_start is ignored
    scene_id = 8'd7; pulse_frame();
    repeat (3) tick();
    chk("coinc_still_bg", pos_data, BG);
    chk("coinc_busy", 24'(fade_busy), 24'h1);
    pulse_frame(); tick(); chk("coinc_l1", pos_data, 24'hBFBFBF);

    // Scene change mid-fade restarts from blank
    pulse_frame(); tick(); chk("restart_l2", pos_data, 24'h7F7F7F);
    scene_id = 8'd9; tick(); tick();
    chk("restart_bg", pos_data, BG);
    pulse_frame(); tick(); chk("restart_l1", pos_data, 24'hBFBFBF);

    // Reset mid-fade
    pulse_frame(); tick(); chk("pre_reset_l2", pos_data, 24'h7F7F7F);
    rst_n = 1'b0; #1;
    chk("arst_pos_data", pos_data, BG);
    chk("arst_pos_valid", 24'(pos_valid), 24'h0);
    chk("arst_fade_busy", 24'(fade_busy), 24'h0);
    scene_id = 8'd0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("post_reset_full", pos_data, 24'h000000);
    chk("post_reset_busy", 24'(fade_busy), 24'h0);

    // Randomised traffic checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      pix_valid   = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 9) == 0);
      layer_en    = NL'($urandom);
      for (int k = 0; k < NL; k++)
        set_layer(k, ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom));
      if ($urandom_range(0, 149) == 0)
        scene_id = 8'($urandom_range(0, 3));
      tick();
    end
    frame_start = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
- Parametrised successor to the fixed-priority VGA pixel selector.
- Merges NUM_LAYERS pixel sources using fixed priority, with per-layer enables and colour-key transparency.
- Adds a frame-synchronised scene transition: on a change of scene_id (the UI mode), the screen blanks to background, then fades the new scene in.
- Sits between the per-page renderers and the VGA timing/output stage.

Parameters:
NUM_LAYERS, 8, number of layer inputs; layer 0 has highest priority.
PIX_W, 24, pixel width, RGB888.
KEY_COLOR, 24'hFF00FF, layer pixel value treated as transparent.
BG_COLOR, 24'hFFFFFF, background colour; also the fade target.
FADE_LOG2, 4, fade step count is 2^FADE_LOG2 (MAX = 2^FADE_LOG2).
HOLD_FRAMES, 2, number of frames held at background after a scene change (≥1).

Ports:
vga_clk  in  1  pixel clock; the single clock.
rst_n  in  1  asynchronous active-low reset.
frame_start  in  1  one-cycle pulse at vertical blanking start.
pix_valid  in  1  current pos is in active video.
scene_id  in  8  current UI mode code.
layer_en  in  NUM_LAYERS  per-layer enable.
layer_data  in  NUM_LAYERS*PIX_W  layer k occupies bits [k*PIX_W +: PIX_W].
pos_data  out  PIX_W  composited pixel.
pos_valid  out  1  pos_data corresponds to an active pixel.
fade_busy  out  1  high while in BLANK or FADE_IN.

Behaviour:
- Reset (async, rst_n low):
  - pos_data = BG_COLOR, pos_valid = 0, fade_busy = 0.
  - State IDLE, level = MAX, scene_q = 8'h00, hold counter = 0.
- Stage 1 (registered):
  - Select the lowest index k with layer_en[k]=1 and layer_data[k] != KEY_COLOR; otherwise select BG_COLOR.
  - If pix_valid = 0, select BG_COLOR.
  - pix_valid is registered alongside.
- Stage 2 (registered):
  - Per channel c (8 bits): out = (p*level + b*(MAX-level)) >> FADE_LOG2, where p is the selected pixel, b is BG_COLOR, and level is FADE_LOG2+1 bits.
  - Intermediate width is 8+FADE_LOG2+1 bits; the result never exceeds 255.
  - level = MAX gives exactly p; level = 0 gives exactly b.
  - pos_valid is the stage-1 valid delayed by one.
- Latency: 2 vga_clk cycles from inputs to pos_data/pos_valid; throughput 1 pixel/cycle.
- Fade FSM, states IDLE, BLANK, FADE_IN:
  - Any state, scene_id != scene_q: scene_q <= scene_id, level <= 0, hold <= HOLD_FRAMES, state <= BLANK. This takes precedence over a coincident frame_start.
  - BLANK, on frame_start: hold decrements. When hold reaches 0, level <= 1 and state <= FADE_IN.
  - FADE_IN, on frame_start: level <= level+1. When level+1 == MAX, state <= IDLE.
  - IDLE: level holds at MAX.
- level changes only on frame_start or on a scene change. A scene change mid-frame takes effect immediately (blank to background); this is intended.
- fade_busy = (state != IDLE), registered together with the state.
- Scene change during BLANK or FADE_IN restarts the sequence from level 0 with a full hold.
- First cycle after reset with scene_id != 0 triggers a fade. This is intended: it gives a power-up fade-in.
- Reset mid-fade aborts immediately to the reset values above.
- layer_en = 0 for all layers yields BG_COLOR, blended with itself, so the output is BG_COLOR at any level.

Decomposition:
- Mode codes, KEY_COLOR and BG_COLOR defaults, and the FSM state encodings belong in the shared VGA parameters include.
- One sub-module: vga_channel_blend, a combinational 8-bit linear interpolation (p, b, level → out), instantiated 3 times in stage 2.
- The priority encoder stays in the top module as a loop.

Test Plan:
(All scenarios use NUM_LAYERS=4, FADE_LOG2=2 (MAX=4), HOLD_FRAMES=1, state IDLE unless stated.)
1. layer_en=4'b0110, L1=0x112233, L2=0x445566, pix_valid=1 → pos_data=0x112233, pos_valid=1 exactly 2 cycles later.
2. Same as 1 with L1=0xFF00FF (key colour) → pos_data=0x445566. With layer_en=0 → 0xFFFFFF. With pix_valid=0 → 0xFFFFFF, pos_valid=0.
3. L0=0x000000 enabled; scene_id 3→5 → fade_busy=1, pos_data=0xFFFFFF until the next frame_start. Then one value per frame: 0xBFBFBF, 0x7F7F7F, 0x3F3F3F, 0x000000. fade_busy falls with the last step.
4. Scene change on the same cycle as frame_start in IDLE → BLANK entered; the frame_start is ignored. Output stays 0xFFFFFF for one full further frame.
5. Scene change at level 2 during FADE_IN → output returns to 0xFFFFFF next cycle. The fade restarts at 0xBFBFBF after the next frame_start.
6. rst_n low at level 2 → immediately pos_data=0xFFFFFF, pos_valid=0, fade_busy=0. After release with scene_id unchanged at 0, output is at full level (no fade).
